// File: rtl/alarm_pkg.sv
// Shared types and limits for the multi-alarm timekeeper.
//   set_sel_t    : field selector for time/alarm editing
//   ring_state_t : per-channel alarm state
//   inc_wrap     : +1 with wrap to 0 past a limit, no carry out
package alarm_pkg;

  typedef enum logic [1:0] {
    SET_NONE = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } set_sel_t;

  typedef enum logic [1:0] {
    RS_IDLE   = 2'd0,
    RS_RING   = 2'd1,
    RS_SNOOZE = 2'd2
  } ring_state_t;

  localparam int unsigned MAX_SEC  = 59;
  localparam int unsigned MAX_MIN  = 59;
  localparam int unsigned MAX_HOUR = 23;

  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] lim);
    return (v >= lim) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: IDLE/RING/SNOOZE state machine with ring and snooze
// second counters.
//   clk, reset     : clock, synchronous active-high reset
//   en             : channel armed; 0 forces IDLE
//   match          : time is rolling onto this channel's hh:mm:00
//   sec_pulse      : 1 Hz tick
//   snooze_edge    : snooze request (RING -> SNOOZE)
//   dismiss_edge   : dismiss request (RING/SNOOZE -> IDLE), beats snooze
//   ringing        : channel is in RING
module alarm_channel
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic match,
  input  logic sec_pulse,
  input  logic snooze_edge,
  input  logic dismiss_edge,
  output logic ringing
);

  localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;

  ring_state_t r_state;
  logic [7:0]  r_ring_cnt;
  logic [11:0] r_snz_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= RS_IDLE;
      r_ring_cnt <= '0;
      r_snz_cnt  <= '0;
    end else if (!en) begin
      r_state <= RS_IDLE;
    end else begin
      case (r_state)
        RS_IDLE: begin
          if (match) begin
            r_state    <= RS_RING;
            r_ring_cnt <= 8'(RING_SEC);
          end
        end
        RS_RING: begin
          if (dismiss_edge) begin
            r_state <= RS_IDLE;
          end else if (snooze_edge) begin
            r_state   <= RS_SNOOZE;
            r_snz_cnt <= 12'(SNZ_TICKS);
          end else if (sec_pulse) begin
            r_ring_cnt <= r_ring_cnt - 8'd1;
            if (r_ring_cnt <= 8'd1) r_state <= RS_IDLE;
          end
        end
        RS_SNOOZE: begin
          if (dismiss_edge) begin
            r_state <= RS_IDLE;
          end else if (sec_pulse) begin
            if (r_snz_cnt <= 12'd1) begin
              r_state    <= RS_RING;
              r_ring_cnt <= 8'(RING_SEC);
              r_snz_cnt  <= '0;
            end else begin
              r_snz_cnt <= r_snz_cnt - 12'd1;
            end
          end
        end
        default: r_state <= RS_IDLE;
      endcase
    end
  end

  assign ringing = (r_state == RS_RING);

endmodule

// File: rtl/bin2bcd.sv
// Combinational binary to two-digit BCD converter (shift-and-add-3).
//   bin : N-bit binary value, 0..99
//   bcd : {tens, ones}
module bin2bcd #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] bin,
  output logic [7:0]   bcd
);

  logic [7:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_acc[3:0] >= 4'd5) w_acc[3:0] = w_acc[3:0] + 4'd3;
      if (w_acc[7:4] >= 4'd5) w_acc[7:4] = w_acc[7:4] + 4'd3;
      w_acc = {w_acc[6:0], bin[N-1-i]};
    end
  end

  assign bcd = w_acc;

endmodule

// File: rtl/multi_alarm_timekeeper.sv
// Timekeeping core: 1 Hz prescaler, hh:mm:ss time of day, NUM_ALARMS hh:mm
// alarms with ring/snooze channels, 12/24 h BCD display.
//   clk, reset          : clock, synchronous active-high reset
//   run                 : time advances on each second tick
//   set_sel             : field being edited (set_sel_t)
//   edit_alarm          : 0 = time target, 1 = alarm[alarm_idx] target
//   alarm_idx           : alarm channel edited/shown
//   add                 : field increment (rising edge)
//   alarm_en            : per-channel arm enable
//   snooze, dismiss     : rising edges act on ringing/snoozing channels
//   mode_12h            : 12 h display when 1
//   hour/min/sec_bcd    : displayed digits; pm = displayed hour >= 12
//   sec_pulse           : one-cycle 1 Hz tick
//   ringing, buzzer     : per-channel RING flags and their OR
module multi_alarm_timekeeper
  import alarm_pkg::*;
#(
  parameter  int unsigned CLK_HZ     = 50_000_000,
  parameter  int unsigned NUM_ALARMS = 4,
  parameter  int unsigned RING_SEC   = 60,
  parameter  int unsigned SNOOZE_MIN = 5,
  localparam int unsigned AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [1:0]            set_sel,
  input  logic                  edit_alarm,
  input  logic [AW-1:0]         alarm_idx,
  input  logic                  add,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  input  logic                  mode_12h,
  output logic [7:0]            hour_bcd,
  output logic [7:0]            min_bcd,
  output logic [7:0]            sec_bcd,
  output logic                  pm,
  output logic                  sec_pulse,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  buzzer
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  set_sel_t w_sel;
  assign w_sel = set_sel_t'(set_sel);

  // Edge detectors: sample, then compare against the previous sample
  logic r_add_cur, r_add_prev, r_snz_cur, r_snz_prev, r_dis_cur, r_dis_prev;
  logic w_add_edge, w_snz_edge, w_dis_edge;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_add_cur  <= 1'b0;
      r_add_prev <= 1'b0;
      r_snz_cur  <= 1'b0;
      r_snz_prev <= 1'b0;
      r_dis_cur  <= 1'b0;
      r_dis_prev <= 1'b0;
    end else begin
      r_add_cur  <= add;
      r_add_prev <= r_add_cur;
      r_snz_cur  <= snooze;
      r_snz_prev <= r_snz_cur;
      r_dis_cur  <= dismiss;
      r_dis_prev <= r_dis_cur;
    end
  end

  assign w_add_edge = r_add_cur & ~r_add_prev;
  assign w_snz_edge = r_snz_cur & ~r_snz_prev;
  assign w_dis_edge = r_dis_cur & ~r_dis_prev;

  // Prescaler; held at 0 while stopped or while the time is being edited
  logic [PW-1:0] r_pre;
  logic          w_time_edit;
  logic          w_sec_pulse;

  assign w_time_edit = (w_sel != SET_NONE) && !edit_alarm;
  assign w_sec_pulse = run && !w_time_edit && (r_pre == PW'(CLK_HZ - 1));

  always_ff @(posedge clk) begin
    if (reset || !run || w_time_edit) r_pre <= '0;
    else if (w_sec_pulse)             r_pre <= '0;
    else                              r_pre <= r_pre + 1'b1;
  end

  // Time of day
  logic [4:0] r_hour, w_nhour;
  logic [5:0] r_min,  w_nmin;
  logic [5:0] r_sec,  w_nsec;

  always_comb begin
    w_nsec  = inc_wrap(r_sec, 6'(MAX_SEC));
    w_nmin  = r_min;
    w_nhour = r_hour;
    if (r_sec == 6'(MAX_SEC)) begin
      w_nmin = inc_wrap(r_min, 6'(MAX_MIN));
      if (r_min == 6'(MAX_MIN)) w_nhour = 5'(inc_wrap(6'(r_hour), 6'(MAX_HOUR)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hour <= '0;
      r_min  <= '0;
      r_sec  <= '0;
    end else if (w_sec_pulse) begin
      r_hour <= w_nhour;
      r_min  <= w_nmin;
      r_sec  <= w_nsec;
    end else if (w_add_edge && w_time_edit) begin
      case (w_sel)
        SET_HOUR: r_hour <= 5'(inc_wrap(6'(r_hour), 6'(MAX_HOUR)));
        SET_MIN:  r_min  <= inc_wrap(r_min, 6'(MAX_MIN));
        SET_SEC:  r_sec  <= inc_wrap(r_sec, 6'(MAX_SEC));
        default:  ;
      endcase
    end
  end

  // Alarm registers; out-of-range index falls back to channel 0
  logic [4:0]    r_al_hour [NUM_ALARMS];
  logic [5:0]    r_al_min  [NUM_ALARMS];
  logic [AW-1:0] w_idx;

  assign w_idx = (32'(alarm_idx) < NUM_ALARMS) ? alarm_idx : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NUM_ALARMS; k++) begin
        r_al_hour[k] <= '0;
        r_al_min[k]  <= '0;
      end
    end else if (w_add_edge && edit_alarm) begin
      case (w_sel)
        SET_HOUR: r_al_hour[w_idx] <= 5'(inc_wrap(6'(r_al_hour[w_idx]), 6'(MAX_HOUR)));
        SET_MIN:  r_al_min[w_idx]  <= inc_wrap(r_al_min[w_idx], 6'(MAX_MIN));
        default:  ;
      endcase
    end
  end

  // Channels: match only on the tick that rolls onto hh:mm:00
  logic [NUM_ALARMS-1:0] w_match;

  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_ch
    assign w_match[k] = w_sec_pulse && (w_nsec == 6'd0) &&
                        (w_nmin == r_al_min[k]) && (w_nhour == r_al_hour[k]);

    alarm_channel #(
      .RING_SEC   (RING_SEC),
      .SNOOZE_MIN (SNOOZE_MIN)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .en           (alarm_en[k]),
      .match        (w_match[k]),
      .sec_pulse    (w_sec_pulse),
      .snooze_edge  (w_snz_edge),
      .dismiss_edge (w_dis_edge),
      .ringing      (ringing[k])
    );
  end

  assign buzzer    = |ringing;
  assign sec_pulse = w_sec_pulse;

  // Display path
  logic [4:0] w_disp_hour, w_hour12, w_hour_show;
  logic [5:0] w_disp_min, w_disp_sec;
  logic [7:0] w_hour_bin, w_min_bin, w_sec_bin;

  assign w_disp_hour = edit_alarm ? r_al_hour[w_idx] : r_hour;
  assign w_disp_min  = edit_alarm ? r_al_min[w_idx]  : r_min;
  assign w_disp_sec  = edit_alarm ? 6'd0             : r_sec;

  always_comb begin
    w_hour12 = w_disp_hour;
    if (w_disp_hour == 5'd0)       w_hour12 = 5'd12;
    else if (w_disp_hour > 5'd12)  w_hour12 = w_disp_hour - 5'd12;
  end

  assign w_hour_show = mode_12h ? w_hour12 : w_disp_hour;
  assign pm          = (w_disp_hour >= 5'd12);

  assign w_hour_bin = {3'b000, w_hour_show};
  assign w_min_bin  = {2'b00, w_disp_min};
  assign w_sec_bin  = {2'b00, w_disp_sec};

  bin2bcd #(.N(8)) u_bcd_hour (.bin(w_hour_bin), .bcd(hour_bcd));
  bin2bcd #(.N(8)) u_bcd_min  (.bin(w_min_bin),  .bcd(min_bcd));
  bin2bcd #(.N(8)) u_bcd_sec  (.bin(w_sec_bin),  .bcd(sec_bcd));

endmodule

// File: tb/tb_multi_alarm_timekeeper.sv
module tb_multi_alarm_timekeeper;

  localparam logic [1:0] S_NONE = 2'd0;
  localparam logic [1:0] S_HOUR = 2'd1;
  localparam logic [1:0] S_MIN  = 2'd2;
  localparam logic [1:0] S_SEC  = 2'd3;

  logic       clk = 1'b0;
  logic       reset, run, edit_alarm, add, snooze, dismiss, mode_12h;
  logic [1:0] set_sel;
  logic [0:0] alarm_idx;
  logic [1:0] alarm_en;
  logic [7:0] hour_bcd, min_bcd, sec_bcd;
  logic       pm, sec_pulse, buzzer;
  logic [1:0] ringing;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: time as seconds of day, alarms as hh/mm
  int m_t = 0;
  int am_h[2] = '{0, 0};
  int am_m[2] = '{0, 0};

  multi_alarm_timekeeper #(
    .CLK_HZ     (4),
    .NUM_ALARMS (2),
    .RING_SEC   (3),
    .SNOOZE_MIN (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .set_sel    (set_sel),
    .edit_alarm (edit_alarm),
    .alarm_idx  (alarm_idx),
    .add        (add),
    .alarm_en   (alarm_en),
    .snooze     (snooze),
    .dismiss    (dismiss),
    .mode_12h   (mode_12h),
    .hour_bcd   (hour_bcd),
    .min_bcd    (min_bcd),
    .sec_bcd    (sec_bcd),
    .pm         (pm),
    .sec_pulse  (sec_pulse),
    .ringing    (ringing),
    .buzzer     (buzzer)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int h12(input int h);
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press();
    add = 1'b1; cyc(2);
    add = 1'b0; cyc(2);
  endtask

  task automatic set_field(input logic [1:0] sel, input int n);
    set_sel = sel;
    repeat (n) press();
    set_sel = S_NONE;
    cyc(1);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    int ch, cm, cs;
    ch = m_t / 3600; cm = (m_t / 60) % 60; cs = m_t % 60;
    edit_alarm = 1'b0;
    set_field(S_HOUR, (h - ch + 24) % 24);
    set_field(S_MIN,  (m - cm + 60) % 60);
    set_field(S_SEC,  (s - cs + 60) % 60);
    m_t = h * 3600 + m * 60 + s;
  endtask

  task automatic set_alarm(input int k, input int h, input int m);
    edit_alarm = 1'b1;
    alarm_idx  = 1'(k);
    set_field(S_HOUR, (h - am_h[k] + 24) % 24);
    set_field(S_MIN,  (m - am_m[k] + 60) % 60);
    edit_alarm = 1'b0;
    am_h[k] = h; am_m[k] = m;
  endtask

  task automatic run_secs(input int n);
    run = 1'b1; cyc(4 * n);
    run = 1'b0; cyc(1);
    m_t = (m_t + n) % 86400;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; set_sel = S_NONE; edit_alarm = 1'b0; alarm_idx = '0;
    add = 1'b0; alarm_en = '0; snooze = 1'b0; dismiss = 1'b0; mode_12h = 1'b0;
    cyc(2);
    @(negedge clk);
    n_checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
      n_errors++; $display("FAIL reset_time: got %h expected 000000", {hour_bcd, min_bcd, sec_bcd});
    end
    n_checks++;
    if ({pm, sec_pulse, ringing, buzzer} !== 5'b0) begin
      n_errors++; $display("FAIL reset_flags: got %b expected 00000", {pm, sec_pulse, ringing, buzzer});
    end
    mode_12h = 1'b1; #1;
    n_checks++;
    if (hour_bcd !== 8'h12) begin
      n_errors++; $display("FAIL reset_hour12: got %h expected 12", hour_bcd);
    end
    mode_12h = 1'b0;
  endtask

  task automatic test_tick();
    int pulses;
    cyc(1);
    for (int pass = 0; pass < 2; pass++) begin
      reset = 1'b0; run = 1'b1;
      pulses = 0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        n_checks++;
        if (sec_pulse !== (i == 3)) begin
          n_errors++; $display("FAIL tick_pulse pass %0d cyc %0d: got %b expected %b", pass, i, sec_pulse, (i == 3));
        end
        if (i == 4) begin
          n_checks++;
          if (sec_bcd !== 8'h01) begin
            n_errors++; $display("FAIL tick_sec pass %0d: got %h expected 01", pass, sec_bcd);
          end
        end
        @(posedge clk); #1;
      end
      if (pass == 0) begin
        cyc(1);
        reset = 1'b1; cyc(1);
        @(negedge clk);
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd, sec_pulse} !== 25'h0) begin
          n_errors++; $display("FAIL midrun_reset: got %h expected 0", {hour_bcd, min_bcd, sec_bcd, sec_pulse});
        end
        @(posedge clk); #1;
      end
    end
    run = 1'b0; cyc(1);
    m_t = 1;
  endtask

  task automatic test_edit_wrap();
    set_time(23, 59, 58);
    @(negedge clk);
    n_checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h235958) begin
      n_errors++; $display("FAIL edit_set: got %h expected 235958", {hour_bcd, min_bcd, sec_bcd});
    end
    cyc(1);
    set_field(S_MIN, 1);
    m_t = 23 * 3600 + 58;
    @(negedge clk);
    n_checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h230058) begin
      n_errors++; $display("FAIL edit_min_nocarry: got %h expected 230058", {hour_bcd, min_bcd, sec_bcd});
    end
    cyc(1);
    set_field(S_HOUR, 1);
    m_t = 58;
    @(negedge clk);
    n_checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000058) begin
      n_errors++; $display("FAIL edit_hour_wrap: got %h expected 000058", {hour_bcd, min_bcd, sec_bcd});
    end
    cyc(1);
    set_time(23, 59, 58);
    run_secs(2);
    @(negedge clk);
    n_checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h000000) begin
      n_errors++; $display("FAIL day_rollover: got %h expected 000000", {hour_bcd, min_bcd, sec_bcd});
    end
    cyc(1);
  endtask

  task automatic test_alarm_ring();
    set_alarm(0, 0, 1);
    alarm_en = 2'b01;
    set_time(0, 1, 0);
    @(negedge clk);
    n_checks++;
    if (ringing !== 2'b00) begin
      n_errors++; $display("FAIL edit_no_match: got %b expected 00", ringing);
    end
    cyc(1);
    set_time(0, 0, 59);
    run_secs(1);
    @(negedge clk);
    n_checks++;
    if ({ringing, buzzer} !== 3'b011) begin
      n_errors++; $display("FAIL ring_start: got %b expected 011", {ringing, buzzer});
    end
    cyc(1);
    run_secs(2);
    @(negedge clk);
    n_checks++;
    if (ringing !== 2'b01) begin
      n_errors++; $display("FAIL ring_hold: got %b expected 01", ringing);
    end
    cyc(1);
    run_secs(1);
    @(negedge clk);
    n_checks++;
    if ({ringing, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL ring_timeout: got %b expected 000", {ringing, buzzer});
    end
    cyc(1);
  endtask

  task automatic test_snooze();
    set_alarm(0, 0, 2);
    set_time(0, 1, 59);
    run_secs(1);
    snooze = 1'b1; cyc(3); snooze = 1'b0; cyc(1);
    @(negedge clk);
    n_checks++;
    if ({ringing, buzzer} !== 3'b000) begin
      n_errors++; $display("FAIL snooze_enter: got %b expected 000", {ringing, buzzer});
    end
    cyc(1);
    run_secs(59);
    @(negedge clk);
    n_checks++;
    if (ringing !== 2'b00) begin
      n_errors++; $display("FAIL snooze_59: got %b expected 00", ringing);
    end
    cyc(1);
    run_secs(1);
    @(negedge clk);
    n_checks++;
    if (ringing !== 2'b01) begin
      n_errors++; $display("FAIL snooze_reringing: got %b expected 01", ringing);
    end
    cyc(1);
    snooze = 1'b1; dismiss = 1'b1; cyc(3);
    snooze = 1'b0; dismiss = 1'b0; cyc(1);
    run_secs(61);
    @(negedge clk);
    n_checks++;
    if (ringing !== 2'b00) begin
      n_errors++; $display("FAIL dismiss_wins: got %b expected 00", ringing);
    end
    cyc(1);
  endtask

  task automatic test_two_alarms();
    set_alarm(0, 0, 5);
    set_alarm(1, 0, 5);
    alarm_en = 2'b11;
    set_time(0, 4, 59);
    run_secs(1);
    @(negedge clk);
    n_checks++;
    if ({ringing, buzzer} !== 3'b111) begin
      n_errors++; $display("FAIL two_ring: got %b expected 111", {ringing, buzzer});
    end
    @(posedge clk); #1;
    alarm_en = 2'b01;
    cyc(1);
    @(negedge clk);
    n_checks++;
    if (ringing !== 2'b01) begin
      n_errors++; $display("FAIL disable_one: got %b expected 01", ringing);
    end
    cyc(1);
    dismiss = 1'b1; cyc(3); dismiss = 1'b0; cyc(1);
    @(negedge clk);
    n_checks++;
    if (ringing !== 2'b00) begin
      n_errors++; $display("FAIL dismiss_ring: got %b expected 00", ringing);
    end
    cyc(1);
    alarm_en = 2'b00;
  endtask

  task automatic test_12h();
    set_time(0, 10, 20);
    mode_12h = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({hour_bcd, min_bcd, pm} !== {8'h12, 8'h10, 1'b0}) begin
      n_errors++; $display("FAIL h12_midnight: got %h/%h/%b expected 12/10/0", hour_bcd, min_bcd, pm);
    end
    cyc(1);
    set_time(13, 10, 20);
    @(negedge clk);
    n_checks++;
    if ({hour_bcd, pm} !== {8'h01, 1'b1}) begin
      n_errors++; $display("FAIL h12_13: got %h/%b expected 01/1", hour_bcd, pm);
    end
    cyc(1);
    mode_12h = 1'b0; edit_alarm = 1'b1; alarm_idx = 1'b1;
    set_sel = S_SEC; press(); press(); set_sel = S_NONE;
    @(negedge clk);
    n_checks++;
    if ({hour_bcd, min_bcd, sec_bcd, pm} !== {8'h00, 8'h05, 8'h00, 1'b0}) begin
      n_errors++; $display("FAIL alarm_view: got %h%h%h/%b expected 000500/0", hour_bcd, min_bcd, sec_bcd, pm);
    end
    mode_12h = 1'b1; #1;
    n_checks++;
    if (hour_bcd !== 8'h12) begin
      n_errors++; $display("FAIL alarm_view_12h: got %h expected 12", hour_bcd);
    end
    edit_alarm = 1'b0; mode_12h = 1'b0; #1;
    n_checks++;
    if ({hour_bcd, min_bcd, sec_bcd} !== 24'h131020) begin
      n_errors++; $display("FAIL alarm_sec_ignored: got %h expected 131020", {hour_bcd, min_bcd, sec_bcd});
    end
    cyc(1);
  endtask

  task automatic test_random();
    int h, m, s, n, k, ch;
    alarm_en = 2'b00;
    for (int it = 0; it < 6; it++) begin
      h = $urandom_range(0, 23); m = $urandom_range(0, 59); s = $urandom_range(0, 59);
      set_time(h, m, s);
      mode_12h = 1'($urandom_range(0, 1));
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 1) begin
          n = $urandom_range(1, 90);
          run_secs(n);
        end
        @(negedge clk);
        ch = m_t / 3600;
        n_checks++;
        if ({hour_bcd, min_bcd, sec_bcd, pm} !==
            {to_bcd(mode_12h ? h12(ch) : ch), to_bcd((m_t / 60) % 60), to_bcd(m_t % 60), 1'(ch >= 12)}) begin
          n_errors++;
          $display("FAIL rand_time it %0d ph %0d: got %h%h%h/%b expected t=%0d s mode12=%b",
                   it, ph, hour_bcd, min_bcd, sec_bcd, pm, m_t, mode_12h);
        end
        cyc(1);
      end
      k = $urandom_range(0, 1);
      set_alarm(k, $urandom_range(0, 23), $urandom_range(0, 59));
      edit_alarm = 1'b1; alarm_idx = 1'(k);
      @(negedge clk);
      n_checks++;
      if ({hour_bcd, min_bcd, sec_bcd} !==
          {to_bcd(mode_12h ? h12(am_h[k]) : am_h[k]), to_bcd(am_m[k]), 8'h00}) begin
        n_errors++;
        $display("FAIL rand_alarm it %0d ch %0d: got %h%h%h expected %0d:%0d", it, k, hour_bcd, min_bcd, sec_bcd, am_h[k], am_m[k]);
      end
      edit_alarm = 1'b0;
      cyc(1);
    end
    mode_12h = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tick();
    test_edit_wrap();
    test_alarm_ring();
    test_snooze();
    test_two_alarms();
    test_12h();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
